// File: rtl/gate_controller_if.sv
// Sensor/PIN inputs and gate/alarm status outputs of the parking-lot entry gate controller.
// The bench drives through the master modport; the controller uses the slave modport.
interface gate_controller_if #(
  parameter int PASS_W = 16,
  parameter int TRY_W  = 2
);
  logic              s01;
  logic              s02;
  logic [PASS_W-1:0] pass;
  logic [PASS_W-1:0] rghtpss;
  logic              gate;
  logic              wrong_pin_alarm;
  logic              lock_alarm;
  logic [TRY_W-1:0]  tries;

  modport master (
    output s01, s02, pass, rghtpss,
    input  gate, wrong_pin_alarm, lock_alarm, tries
  );

  modport slave (
    input  s01, s02, pass, rghtpss,
    output gate, wrong_pin_alarm, lock_alarm, tries
  );
endinterface

// File: rtl/gate_controller.sv
// Parking-lot entry gate controller: PIN check opens the gate, repeated misses raise a PIN alarm,
// and tailgating raises a lock alarm. Both alarms clear only on a correct PIN or on reset.
module gate_controller #(
  parameter int PASS_W    = 16,
  parameter int MAX_TRIES = 3,
  parameter int TRY_W     = 2
) (
  input logic              clk,
  input logic              rst,
  gate_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VERIFY    = 3'd1,
    OPEN      = 3'd2,
    PIN_ALARM = 3'd3,
    BLOCK     = 3'd4
  } state_t;

  localparam logic [TRY_W:0]   MAX_EXT = (TRY_W+1)'(MAX_TRIES);
  localparam logic [TRY_W-1:0] MAX_T   = TRY_W'(MAX_TRIES);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [TRY_W-1:0] tries_r;
  logic [TRY_W-1:0] tries_nxt_s;
  logic             gate_r;
  logic             wpa_r;
  logic             lock_r;
  logic             match_s;
  logic             tailgate_s;
  logic [TRY_W:0]   tries_inc_s;

  assign match_s     = (bus.pass == bus.rghtpss);
  assign tailgate_s  = bus.s01 & bus.s02;
  assign tries_inc_s = {1'b0, tries_r} + {{TRY_W{1'b0}}, 1'b1};

  // Next-state and attempt-counter decode
  always_comb begin
    state_nxt_s = state_r;
    tries_nxt_s = tries_r;
    case (state_r)
      IDLE: begin
        tries_nxt_s = {TRY_W{1'b0}};
        if (tailgate_s) begin
          state_nxt_s = BLOCK;
        end else if (bus.s01 && !bus.s02) begin
          state_nxt_s = VERIFY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      VERIFY: begin
        if (tailgate_s) begin
          state_nxt_s = BLOCK;
        end else if (match_s) begin
          state_nxt_s = OPEN;
          tries_nxt_s = {TRY_W{1'b0}};
        end else if (tries_inc_s < MAX_EXT) begin
          tries_nxt_s = tries_inc_s[TRY_W-1:0];
        end else begin
          state_nxt_s = PIN_ALARM;
          tries_nxt_s = MAX_T;
        end
      end
      OPEN: begin
        if (tailgate_s) begin
          state_nxt_s = BLOCK;
        end else if (bus.s02 && !bus.s01) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OPEN;
        end
      end
      PIN_ALARM: begin
        if (match_s) begin
          state_nxt_s = IDLE;
          tries_nxt_s = {TRY_W{1'b0}};
        end else begin
          tries_nxt_s = MAX_T;
        end
      end
      BLOCK: begin
        if (match_s) begin
          state_nxt_s = IDLE;
          tries_nxt_s = {TRY_W{1'b0}};
        end else begin
          state_nxt_s = BLOCK;
        end
      end
      default: begin
        // Corrupted encoding falls back to a safe closed, quiet gate
        state_nxt_s = IDLE;
        tries_nxt_s = {TRY_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs; outputs follow the state being entered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      tries_r <= {TRY_W{1'b0}};
      gate_r  <= 1'b0;
      wpa_r   <= 1'b0;
      lock_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tries_r <= tries_nxt_s;
      gate_r  <= (state_nxt_s == OPEN);
      wpa_r   <= (state_nxt_s == PIN_ALARM);
      lock_r  <= (state_nxt_s == BLOCK);
    end
  end

  assign bus.gate            = gate_r;
  assign bus.wrong_pin_alarm = wpa_r;
  assign bus.lock_alarm      = lock_r;
  assign bus.tries           = tries_r;

endmodule

// File: tb/tb_gate_controller.sv
// Directed bench for gate_controller: flag-based behavioural model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_gate_controller;

  localparam int MAXT = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   check_en = 1'b0;

  gate_controller_if #(.PASS_W(16), .TRY_W(2)) bus ();

  gate_controller #(.PASS_W(16), .MAX_TRIES(MAXT), .TRY_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: the gate is either open, alarmed (pin or lock), checking a PIN, or waiting
  bit m_gate  = 1'b0;
  bit m_pin   = 1'b0;
  bit m_lock  = 1'b0;
  bit m_check = 1'b0;
  int m_tries = 0;

  always @(posedge clk) begin
    bit hit;
    hit = (bus.pass === bus.rghtpss);
    if (!rst) begin
      m_gate = 0; m_pin = 0; m_lock = 0; m_check = 0; m_tries = 0;
    end else if (m_pin) begin
      if (hit) begin m_pin = 0; m_tries = 0; end
    end else if (m_lock) begin
      if (hit) begin m_lock = 0; m_tries = 0; end
    end else if (bus.s01 && bus.s02) begin
      m_lock = 1; m_gate = 0; m_check = 0;
    end else if (m_gate) begin
      if (bus.s02 && !bus.s01) m_gate = 0;
    end else if (m_check) begin
      if (hit) begin
        m_gate = 1; m_tries = 0; m_check = 0;
      end else if (m_tries + 1 == MAXT) begin
        m_pin = 1; m_tries = MAXT; m_check = 0;
      end else begin
        m_tries = m_tries + 1;
      end
    end else if (bus.s01 && !bus.s02) begin
      m_check = 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("model.gate", int'(bus.gate), int'(m_gate));
      chk("model.wrong_pin_alarm", int'(bus.wrong_pin_alarm), int'(m_pin));
      chk("model.lock_alarm", int'(bus.lock_alarm), int'(m_lock));
      chk("model.tries", int'(bus.tries), m_tries);
      chk("onehot", int'(bus.gate) + int'(bus.wrong_pin_alarm) + int'(bus.lock_alarm) <= 1 ? 1 : 0, 1);
    end
  end

  task automatic step(input bit r, input bit a, input bit b, input logic [15:0] p);
    rst      = r;
    bus.s01  = a;
    bus.s02  = b;
    bus.pass = p;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic outs(input string nm, input int g, input int w, input int l, input int t);
    chk({nm, ".gate"}, int'(bus.gate), g);
    chk({nm, ".wpa"}, int'(bus.wrong_pin_alarm), w);
    chk({nm, ".lock"}, int'(bus.lock_alarm), l);
    chk({nm, ".tries"}, int'(bus.tries), t);
  endtask

  localparam logic [15:0] OK  = 16'h4037;
  localparam logic [15:0] BAD = 16'h4027;

  initial begin
    rst = 1'b0; bus.s01 = 1'b1; bus.s02 = 1'b1; bus.pass = OK; bus.rghtpss = OK;

    // 1: reset with tailgate pattern present
    step(1'b0, 1'b1, 1'b1, OK);
    check_en = 1'b1;
    outs("t1a", 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1, OK);
    outs("t1b", 0, 0, 0, 0);

    // 2: arrival, correct PIN, vehicle passes
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    outs("t2.verify", 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, OK);
    outs("t2.open", 1, 0, 0, 0);
    step(1'b1, 1'b0, 1'b1, OK);
    outs("t2.pass", 0, 0, 0, 0);

    // 3: two misses then a correct PIN on the last allowed attempt
    step(1'b1, 1'b1, 1'b0, 16'h4031);
    step(1'b1, 1'b1, 1'b0, 16'h4031);
    outs("t3.try1", 0, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 16'h4031);
    outs("t3.try2", 0, 0, 0, 2);
    step(1'b1, 1'b0, 1'b0, OK);
    outs("t3.open", 1, 0, 0, 0);
    step(1'b1, 1'b0, 1'b1, OK);
    outs("t3.idle", 0, 0, 0, 0);

    // 4: exhaust attempts, alarm holds with sensors ignored, correct PIN clears
    step(1'b1, 1'b1, 1'b0, BAD);
    step(1'b1, 1'b1, 1'b0, BAD);
    outs("t4.try1", 0, 0, 0, 1);
    step(1'b1, 1'b1, 1'b0, BAD);
    outs("t4.try2", 0, 0, 0, 2);
    step(1'b1, 1'b1, 1'b0, BAD);
    outs("t4.alarm", 0, 1, 0, 3);
    step(1'b1, 1'b1, 1'b1, BAD);
    step(1'b1, 1'b0, 1'b1, BAD);
    step(1'b1, 1'b1, 1'b0, 16'h1234);
    step(1'b1, 1'b0, 1'b0, BAD);
    outs("t4.hold", 0, 1, 0, 3);
    step(1'b1, 1'b0, 1'b0, OK);
    outs("t4.clear", 0, 0, 0, 0);

    // 5a: tailgate from IDLE, toggling sensors keeps the lock, correct PIN clears
    step(1'b1, 1'b1, 1'b1, BAD);
    outs("t5.lock", 0, 0, 1, 0);
    step(1'b1, 1'b0, 1'b1, BAD);
    step(1'b1, 1'b1, 1'b0, BAD);
    step(1'b1, 1'b0, 1'b0, BAD);
    outs("t5.hold", 0, 0, 1, 0);
    step(1'b1, 1'b0, 1'b0, OK);
    outs("t5.clear", 0, 0, 0, 0);

    // 5b: tailgate while the gate is open
    step(1'b1, 1'b1, 1'b0, BAD);
    step(1'b1, 1'b1, 1'b0, OK);
    outs("t5.open", 1, 0, 0, 0);
    step(1'b1, 1'b1, 1'b1, BAD);
    outs("t5.openlock", 0, 0, 1, 0);
    step(1'b1, 1'b0, 1'b1, BAD);
    step(1'b1, 1'b0, 1'b0, OK);
    outs("t5.clear2", 0, 0, 0, 0);

    // 6a: reset while open, then a fresh arrival verifies
    step(1'b1, 1'b1, 1'b0, BAD);
    step(1'b1, 1'b0, 1'b0, OK);
    outs("t6.open", 1, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, OK);
    outs("t6.rst1", 0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, BAD);
    step(1'b1, 1'b1, 1'b0, BAD);
    outs("t6.verify1", 0, 0, 0, 1);

    // 6b: reset during PIN alarm
    step(1'b1, 1'b1, 1'b0, BAD);
    step(1'b1, 1'b1, 1'b0, BAD);
    outs("t6.alarm", 0, 1, 0, 3);
    step(1'b0, 1'b1, 1'b0, BAD);
    outs("t6.rst2", 0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, BAD);
    step(1'b1, 1'b0, 1'b0, BAD);
    outs("t6.verify2", 0, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, OK);
    outs("t6.open2", 1, 0, 0, 0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
